// File: rtl/io_device_port.sv
// io_device_port: single-outstanding command port between a manager and an
// IO device. A command is latched, issued to the device, optionally waits for
// a response (with a timeout), and the result is handed back to the manager as
// a writeback. Handshake outputs are registered and depend on state only.
module io_device_port #(
    parameter int PORTWIDTH     = 16,
    parameter int TIMEOUTCYCLES = 255
) (
    input  logic                 clk,
    input  logic                 clk_en,
    input  logic                 sync_rst,
    // Manager command channel
    input  logic                 CmdREQ,
    output logic                 CmdACK,
    input  logic                 CmdResponseRequested,
    input  logic [3:0]           CmdDestReg,
    input  logic [PORTWIDTH-1:0] CmdData,
    // Device command channel
    output logic                 IOOut_REQ,
    input  logic                 IOOut_ACK,
    output logic                 IOOut_ResponseRequested,
    output logic [3:0]           IOOut_DestReg,
    output logic [PORTWIDTH-1:0] IOOut_Data,
    // Device response channel
    input  logic                 IOIn_REQ,
    output logic                 IOIn_ACK,
    input  logic                 IOIn_RegResponseFlag,
    input  logic                 IOIn_MemResponseFlag,
    input  logic [3:0]           IOIn_DestReg,
    input  logic [PORTWIDTH-1:0] IOIn_Data,
    // Manager writeback channel
    output logic                 WbREQ,
    input  logic                 WbACK,
    output logic [3:0]           WbDestReg,
    output logic [PORTWIDTH-1:0] WbData,
    output logic                 WbMemFlag,
    output logic                 WbTimeout,
    // Status
    output logic                 Busy
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_ISSUE     = 2'd1,
        S_WAIT_RESP = 2'd2,
        S_WRITEBACK = 2'd3
    } state_t;

    // Handshake strobes, registered together with the state they belong to.
    typedef struct packed {
        logic cmd_ack;
        logic io_out_req;
        logic io_in_ack;
        logic wb_req;
        logic busy;
    } strobes_t;

    // Last counter value spent in WAIT_RESP before the response is declared lost.
    localparam logic [15:0] TERMINAL_COUNT = 16'(TIMEOUTCYCLES - 1);

    // Strobe pattern that must be visible while sitting in state s.
    function automatic strobes_t strobes(input state_t s);
        strobes_t v;
        v            = '0;
        v.cmd_ack    = (s == S_IDLE);
        v.io_out_req = (s == S_ISSUE);
        v.io_in_ack  = (s == S_WAIT_RESP);
        v.wb_req     = (s == S_WRITEBACK);
        v.busy       = (s != S_IDLE);
        return v;
    endfunction

    state_t                 r_state;
    strobes_t               r_strb;
    logic [15:0]            r_count;

    logic                   r_resp_req;
    logic [3:0]             r_tag;
    logic [PORTWIDTH-1:0]   r_data;

    logic [3:0]             r_wb_tag;
    logic [PORTWIDTH-1:0]   r_wb_data;
    logic                   r_wb_mem;
    logic                   r_wb_timeout;

    // Channel transfers: both sides agree in a cycle where state may advance.
    logic w_cmd_xfer;
    logic w_out_xfer;
    logic w_in_xfer;
    logic w_wb_xfer;
    logic w_terminal;
    logic w_resp_useful;

    assign w_cmd_xfer    = CmdREQ    & r_strb.cmd_ack    & clk_en;
    assign w_out_xfer    = r_strb.io_out_req & IOOut_ACK & clk_en;
    assign w_in_xfer     = IOIn_REQ  & r_strb.io_in_ack  & clk_en;
    assign w_wb_xfer     = r_strb.wb_req & WbACK         & clk_en;
    assign w_terminal    = (r_count == TERMINAL_COUNT);
    assign w_resp_useful = IOIn_RegResponseFlag | IOIn_MemResponseFlag;

    // Port FSM: state, registered strobes, timeout counter and payload latches.
    // NOTE: every register here is assigned with <= so all of them update from
    // the same pre-edge values; a blocking = would let later lines see new state.
    always_ff @(posedge clk) begin
        if (sync_rst) begin
            r_state      <= S_IDLE;
            r_strb       <= strobes(S_IDLE);
            r_count      <= '0;
            r_resp_req   <= 1'b0;
            r_tag        <= '0;
            r_data       <= '0;
            r_wb_tag     <= '0;
            r_wb_data    <= '0;
            r_wb_mem     <= 1'b0;
            r_wb_timeout <= 1'b0;
        end else if (clk_en) begin
            case (r_state)
                S_IDLE: begin
                    if (w_cmd_xfer) begin
                        r_resp_req <= CmdResponseRequested;
                        r_tag      <= CmdDestReg;
                        r_data     <= CmdData;
                        r_state    <= S_ISSUE;
                        r_strb     <= strobes(S_ISSUE);
                    end
                end

                S_ISSUE: begin
                    if (w_out_xfer) begin
                        if (r_resp_req) begin
                            r_count <= '0;
                            r_state <= S_WAIT_RESP;
                            r_strb  <= strobes(S_WAIT_RESP);
                        end else begin
                            r_state <= S_IDLE;
                            r_strb  <= strobes(S_IDLE);
                        end
                    end
                end

                S_WAIT_RESP: begin
                    r_count <= r_count + 16'd1;
                    // A response arriving on the terminal count wins over the timeout.
                    if (w_in_xfer) begin
                        if (w_resp_useful) begin
                            r_wb_tag     <= IOIn_DestReg;
                            r_wb_data    <= IOIn_Data;
                            r_wb_mem     <= IOIn_MemResponseFlag;
                            r_wb_timeout <= 1'b0;
                            r_state      <= S_WRITEBACK;
                            r_strb       <= strobes(S_WRITEBACK);
                        end else begin
                            r_state <= S_IDLE;
                            r_strb  <= strobes(S_IDLE);
                        end
                    end else if (w_terminal) begin
                        r_wb_tag     <= r_tag;
                        r_wb_data    <= '1;
                        r_wb_mem     <= 1'b0;
                        r_wb_timeout <= 1'b1;
                        r_state      <= S_WRITEBACK;
                        r_strb       <= strobes(S_WRITEBACK);
                    end
                end

                S_WRITEBACK: begin
                    if (w_wb_xfer) begin
                        r_state <= S_IDLE;
                        r_strb  <= strobes(S_IDLE);
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                    r_strb  <= strobes(S_IDLE);
                end
            endcase
        end
    end

    assign CmdACK                  = r_strb.cmd_ack;
    assign IOOut_REQ               = r_strb.io_out_req;
    assign IOIn_ACK                = r_strb.io_in_ack;
    assign WbREQ                   = r_strb.wb_req;
    assign Busy                    = r_strb.busy;

    assign IOOut_ResponseRequested = r_resp_req;
    assign IOOut_DestReg           = r_tag;
    assign IOOut_Data              = r_data;

    assign WbDestReg               = r_wb_tag;
    assign WbData                  = r_wb_data;
    assign WbMemFlag               = r_wb_mem;
    assign WbTimeout               = r_wb_timeout;

endmodule

// File: tb/tb_io_device_port.sv
// tb_io_device_port: directed scenarios with literal expectations, then a long
// randomized run. A transaction-level model tracks what the port owes each
// side and a compare process checks every output on every falling edge.
module tb_io_device_port;

    localparam int PW = 16;
    localparam int TO = 4;

    logic          clk;
    logic          clk_en;
    logic          sync_rst;
    logic          CmdREQ;
    logic          CmdACK;
    logic          CmdResponseRequested;
    logic [3:0]    CmdDestReg;
    logic [PW-1:0] CmdData;
    logic          IOOut_REQ;
    logic          IOOut_ACK;
    logic          IOOut_ResponseRequested;
    logic [3:0]    IOOut_DestReg;
    logic [PW-1:0] IOOut_Data;
    logic          IOIn_REQ;
    logic          IOIn_ACK;
    logic          IOIn_RegResponseFlag;
    logic          IOIn_MemResponseFlag;
    logic [3:0]    IOIn_DestReg;
    logic [PW-1:0] IOIn_Data;
    logic          WbREQ;
    logic          WbACK;
    logic [3:0]    WbDestReg;
    logic [PW-1:0] WbData;
    logic          WbMemFlag;
    logic          WbTimeout;
    logic          Busy;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 0;

    io_device_port #(.PORTWIDTH(PW), .TIMEOUTCYCLES(TO)) dut (
        .clk                    (clk),
        .clk_en                 (clk_en),
        .sync_rst               (sync_rst),
        .CmdREQ                 (CmdREQ),
        .CmdACK                 (CmdACK),
        .CmdResponseRequested   (CmdResponseRequested),
        .CmdDestReg             (CmdDestReg),
        .CmdData                (CmdData),
        .IOOut_REQ              (IOOut_REQ),
        .IOOut_ACK              (IOOut_ACK),
        .IOOut_ResponseRequested(IOOut_ResponseRequested),
        .IOOut_DestReg          (IOOut_DestReg),
        .IOOut_Data             (IOOut_Data),
        .IOIn_REQ               (IOIn_REQ),
        .IOIn_ACK               (IOIn_ACK),
        .IOIn_RegResponseFlag   (IOIn_RegResponseFlag),
        .IOIn_MemResponseFlag   (IOIn_MemResponseFlag),
        .IOIn_DestReg           (IOIn_DestReg),
        .IOIn_Data              (IOIn_Data),
        .WbREQ                  (WbREQ),
        .WbACK                  (WbACK),
        .WbDestReg              (WbDestReg),
        .WbData                 (WbData),
        .WbMemFlag              (WbMemFlag),
        .WbTimeout              (WbTimeout),
        .Busy                   (Busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // The port owes at most one thing at a time: a command to the device, a
    // response wait, or a writeback to the manager. Nothing owed means idle.
    bit            m_owe_cmd, m_owe_wait, m_owe_wb;
    bit            m_rr;
    logic [3:0]    m_tag;
    logic [PW-1:0] m_data;
    int            m_waited;
    logic [3:0]    m_wb_tag;
    logic [PW-1:0] m_wb_data;
    bit            m_wb_mem, m_wb_to;

    function automatic bit m_idle();
        return !(m_owe_cmd || m_owe_wait || m_owe_wb);
    endfunction

    // Model advances on the same edge the DUT samples its inputs.
    always @(posedge clk) begin
        if (sync_rst) begin
            m_owe_cmd = 0; m_owe_wait = 0; m_owe_wb = 0;
            m_rr = 0; m_tag = '0; m_data = '0; m_waited = 0;
            m_wb_tag = '0; m_wb_data = '0; m_wb_mem = 0; m_wb_to = 0;
        end else if (clk_en) begin
            if (m_idle()) begin
                if (CmdREQ) begin
                    m_rr = CmdResponseRequested; m_tag = CmdDestReg; m_data = CmdData;
                    m_owe_cmd = 1;
                end
            end else if (m_owe_cmd) begin
                if (IOOut_ACK) begin
                    m_owe_cmd = 0;
                    if (m_rr) begin m_owe_wait = 1; m_waited = 0; end
                end
            end else if (m_owe_wait) begin
                if (IOIn_REQ) begin
                    m_owe_wait = 0;
                    if (IOIn_RegResponseFlag || IOIn_MemResponseFlag) begin
                        m_owe_wb = 1; m_wb_tag = IOIn_DestReg; m_wb_data = IOIn_Data;
                        m_wb_mem = IOIn_MemResponseFlag; m_wb_to = 0;
                    end
                end else begin
                    m_waited++;
                    if (m_waited == TO) begin
                        m_owe_wait = 0; m_owe_wb = 1; m_wb_tag = m_tag;
                        m_wb_data = '1; m_wb_mem = 0; m_wb_to = 1;
                    end
                end
            end else if (m_owe_wb && WbACK) begin
                m_owe_wb = 0;
            end
        end
    end

    // Compare every output against the model on the falling edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            check("CmdACK",       CmdACK,                  m_idle());
            check("IOOut_REQ",    IOOut_REQ,               m_owe_cmd);
            check("IOIn_ACK",     IOIn_ACK,                m_owe_wait);
            check("WbREQ",        WbREQ,                   m_owe_wb);
            check("Busy",         Busy,                    !m_idle());
            check("IOOut_RR",     IOOut_ResponseRequested, m_rr);
            check("IOOut_Dest",   IOOut_DestReg,           m_tag);
            check("IOOut_Data",   IOOut_Data,              m_data);
            check("WbDestReg",    WbDestReg,               m_wb_tag);
            check("WbData",       WbData,                  m_wb_data);
            check("WbMemFlag",    WbMemFlag,               m_wb_mem);
            check("WbTimeout",    WbTimeout,               m_wb_to);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_inputs();
        clk_en = 1; sync_rst = 0;
        CmdREQ = 0; CmdResponseRequested = 0; CmdDestReg = '0; CmdData = '0;
        IOOut_ACK = 0; IOIn_REQ = 0; IOIn_RegResponseFlag = 0; IOIn_MemResponseFlag = 0;
        IOIn_DestReg = '0; IOIn_Data = '0; WbACK = 0;
    endtask

    task automatic send_cmd(input logic rr, input logic [3:0] tag, input logic [PW-1:0] data);
        int n = 0;
        while (CmdACK !== 1'b1 && n < 50) begin tick(); n++; end
        check("cmd_ack_wait", CmdACK, 1);
        CmdREQ = 1; CmdResponseRequested = rr; CmdDestReg = tag; CmdData = data;
        tick();
        CmdREQ = 0;
        check("issue_req", IOOut_REQ, 1);
    endtask

    // Device accepts the issued command; port then sits in its first wait cycle.
    task automatic device_ack();
        IOOut_ACK = 1;
        tick();
        IOOut_ACK = 0;
    endtask

    task automatic respond(input logic reg_f, input logic mem_f, input logic [3:0] tag, input logic [PW-1:0] data);
        IOIn_REQ = 1; IOIn_RegResponseFlag = reg_f; IOIn_MemResponseFlag = mem_f;
        IOIn_DestReg = tag; IOIn_Data = data;
        tick();
        IOIn_REQ = 0; IOIn_RegResponseFlag = 0; IOIn_MemResponseFlag = 0;
    endtask

    task automatic manager_ack();
        WbACK = 1;
        tick();
        WbACK = 0;
    endtask

    // Ticks until WbREQ rises, bounded; returns the number of ticks taken.
    task automatic wait_wb(output int n);
        n = 0;
        while (WbREQ !== 1'b1 && n < 40) begin tick(); n++; end
    endtask

    initial begin
        int n;
        idle_inputs();
        sync_rst = 1;
        tick();
        cmp_en = 1;
        tick();
        sync_rst = 0;

        // Reset values
        check("rst_CmdACK", CmdACK, 1);
        check("rst_IOOut_REQ", IOOut_REQ, 0);
        check("rst_IOIn_ACK", IOIn_ACK, 0);
        check("rst_WbREQ", WbREQ, 0);
        check("rst_Busy", Busy, 0);
        check("rst_WbData", WbData, 0);
        check("rst_IOOut_Data", IOOut_Data, 0);

        // Fire-and-forget command, device acks two cycles later
        send_cmd(0, 4'd3, 16'h00A5);
        check("ff_data0", IOOut_Data, 16'h00A5);
        check("ff_tag0", IOOut_DestReg, 3);
        tick();
        check("ff_data1", IOOut_Data, 16'h00A5);
        check("ff_req1", IOOut_REQ, 1);
        device_ack();
        check("ff_idle", CmdACK, 1);
        check("ff_no_wb", WbREQ, 0);
        check("ff_no_wait", IOIn_ACK, 0);

        // Register response, writeback held off for three cycles
        send_cmd(1, 4'd7, 16'h0BEE);
        device_ack();
        check("rsp_wait", IOIn_ACK, 1);
        tick(); tick();
        respond(1, 0, 4'd7, 16'h1234);
        for (int i = 0; i < 4; i++) begin
            check("rsp_wbreq", WbREQ, 1);
            check("rsp_wbdata", WbData, 16'h1234);
            check("rsp_wbtag", WbDestReg, 7);
            check("rsp_wbto", WbTimeout, 0);
            if (i < 3) tick();
        end
        manager_ack();
        check("rsp_idle", CmdACK, 1);
        check("rsp_wb_done", WbREQ, 0);

        // No response: timeout writeback four cycles after entering the wait
        send_cmd(1, 4'd5, 16'h0001);
        device_ack();
        wait_wb(n);
        check("to_latency", n, 4);
        check("to_wbdata", WbData, 16'hFFFF);
        check("to_flag", WbTimeout, 1);
        check("to_tag", WbDestReg, 5);
        check("to_mem", WbMemFlag, 0);
        manager_ack();

        // Response exactly on terminal count wins
        send_cmd(1, 4'd9, 16'h0002);
        device_ack();
        tick(); tick(); tick();
        check("tc_still_wait", IOIn_ACK, 1);
        respond(1, 0, 4'd9, 16'h0042);
        check("tc_wbdata", WbData, 16'h0042);
        check("tc_flag", WbTimeout, 0);
        manager_ack();

        // clk_en low three cycles during the wait stretches the timeout by three
        send_cmd(1, 4'd1, 16'h0003);
        device_ack();
        tick();
        clk_en = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("freeze_wait", IOIn_ACK, 1);
            check("freeze_nowb", WbREQ, 0);
        end
        clk_en = 1;
        wait_wb(n);
        check("freeze_latency", n + 4, 7);
        manager_ack();

        // Response with no flags is dropped
        send_cmd(1, 4'd2, 16'h0004);
        device_ack();
        respond(0, 0, 4'd2, 16'h5555);
        check("drop_idle", CmdACK, 1);
        check("drop_nowb", WbREQ, 0);

        // Reset in ISSUE
        send_cmd(0, 4'd6, 16'h7777);
        sync_rst = 1;
        tick();
        sync_rst = 0;
        check("rst_issue_ack", CmdACK, 1);
        check("rst_issue_req", IOOut_REQ, 0);
        check("rst_issue_data", IOOut_Data, 0);

        // Reset in WRITEBACK, with clk_en low
        send_cmd(1, 4'd8, 16'h0008);
        device_ack();
        respond(1, 0, 4'd8, 16'h0808);
        check("rst_wb_pre", WbREQ, 1);
        sync_rst = 1; clk_en = 0;
        tick();
        sync_rst = 0; clk_en = 1;
        check("rst_wb_ack", CmdACK, 1);
        check("rst_wb_req", WbREQ, 0);
        check("rst_wb_data", WbData, 0);

        // Both flags: memory-bound writeback after reset recovery
        send_cmd(1, 4'd4, 16'h0009);
        device_ack();
        respond(1, 1, 4'd11, 16'hBEEF);
        check("both_mem", WbMemFlag, 1);
        check("both_data", WbData, 16'hBEEF);
        check("both_tag", WbDestReg, 11);
        manager_ack();
        check("both_idle", CmdACK, 1);

        // Randomized traffic, checked by the compare process
        for (int c = 0; c < 3000; c++) begin
            clk_en               = ($urandom_range(0, 9) != 0);
            sync_rst             = ($urandom_range(0, 149) == 0);
            CmdREQ               = $urandom_range(0, 1);
            CmdResponseRequested = $urandom_range(0, 3) != 0;
            CmdDestReg           = 4'($urandom);
            CmdData              = PW'($urandom);
            IOOut_ACK            = $urandom_range(0, 1);
            IOIn_REQ             = ($urandom_range(0, 4) == 0);
            IOIn_RegResponseFlag = $urandom_range(0, 1);
            IOIn_MemResponseFlag = $urandom_range(0, 1);
            IOIn_DestReg         = 4'($urandom);
            IOIn_Data            = PW'($urandom);
            WbACK                = $urandom_range(0, 1);
            tick();
        end
        idle_inputs();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/io_device_port.md
IO_DEVICE_PORT -- requirements
Module: io_device_port

Interface
REQ-001 SHALL have parameter PORTWIDTH, default 16: data width of the command, response and writeback payloads.
REQ-002 SHALL have parameter TIMEOUTCYCLES, default 255: number of WAIT_RESP cycles before a response is declared lost; legal range 2..65535.
REQ-003 SHALL have ports:
- clk  in  1  single clock; all state on the rising edge.
- clk_en  in  1  global enable; when low, all state holds.
- sync_rst  in  1  synchronous, active-high reset.
- CmdREQ  in  1  manager command valid.
- CmdACK  out  1  port ready for a command.
- CmdResponseRequested  in  1  command expects a device response.
- CmdDestReg  in  4  destination register tag.
- CmdData  in  PORTWIDTH  command payload.
- IOOut_REQ  out  1  command valid to device.
- IOOut_ACK  in  1  device accepts the command.
- IOOut_ResponseRequested  out  1  latched CmdResponseRequested.
- IOOut_DestReg  out  4  latched tag.
- IOOut_Data  out  PORTWIDTH  latched payload.
- IOIn_REQ  in  1  device response valid.
- IOIn_ACK  out  1  port accepts the response.
- IOIn_RegResponseFlag  in  1  response targets the register file.
- IOIn_MemResponseFlag  in  1  response targets memory.
- IOIn_DestReg  in  4  response tag.
- IOIn_Data  in  PORTWIDTH  response payload.
- WbREQ  out  1  writeback valid to manager.
- WbACK  in  1  manager accepts the writeback.
- WbDestReg  out  4  writeback tag.
- WbData  out  PORTWIDTH  writeback payload.
- WbMemFlag  out  1  writeback is memory-bound.
- WbTimeout  out  1  writeback is a timeout marker.
- Busy  out  1  high in any state other than IDLE.

Function
REQ-004 SHALL treat a transfer on any channel as REQ && ACK && clk_en in the same cycle; no transfer occurs when clk_en is low.
REQ-005 SHALL implement the FSM states IDLE, ISSUE, WAIT_RESP and WRITEBACK, with at most one command outstanding.
REQ-006 IDLE: CmdACK = 1; on a Cmd transfer, SHALL latch ResponseRequested, DestReg and Data and go to ISSUE next cycle.
REQ-007 ISSUE: IOOut_REQ = 1 with the latched fields held stable; on IOOut transfer, SHALL go to WAIT_RESP if ResponseRequested = 1, otherwise to IDLE.
REQ-008 WAIT_RESP: IOIn_ACK = 1; SHALL clear the timeout counter on entry and increment it each clk_en cycle.
REQ-009 WAIT_RESP, on IOIn transfer with RegResponseFlag or MemResponseFlag set:
- SHALL capture IOIn_DestReg, IOIn_Data and MemResponseFlag into the Wb registers.
- SHALL set WbTimeout = 0.
- SHALL go to WRITEBACK.
REQ-010 WAIT_RESP, on IOIn transfer with both flags low: SHALL discard the response and go to IDLE with no writeback.
REQ-011 WAIT_RESP, when the counter reaches TIMEOUTCYCLES-1 with no IOIn transfer:
- SHALL load WbDestReg = latched tag, WbData = all ones, WbMemFlag = 0, WbTimeout = 1.
- SHALL go to WRITEBACK.
REQ-012 An IOIn transfer in the same cycle as terminal count SHALL take priority over the timeout.
REQ-013 WRITEBACK: WbREQ = 1 with payload held stable; on Wb transfer, SHALL go to IDLE, with CmdACK high the following cycle.
REQ-014 IOIn_ACK SHALL be 0 outside WAIT_RESP, so unsolicited device responses stall at the device.
REQ-015 CmdACK, IOOut_REQ, IOIn_ACK and WbREQ SHALL each be a function of the current state only, with no combinational path from any input.
REQ-016 While clk_en is low, SHALL hold state, counter and all outputs.
REQ-017 If both response flags are set, SHALL set WbMemFlag = 1 and still write back.

Reset
REQ-018 On sync_rst, SHALL go to IDLE and clear the counter and all latched fields.
REQ-019 Values after reset:
- CmdACK = 1.
- IOOut_REQ = IOIn_ACK = WbREQ = Busy = WbTimeout = WbMemFlag = 0.
- All data and tag outputs = 0.
REQ-020 sync_rst SHALL take effect regardless of clk_en and SHALL abandon any in-flight command with no writeback.

Verification
REQ-021 Command Data = 0x00A5, Tag = 3, ResponseRequested = 0; device ACKs 2 cycles later -> IOOut_Data = 0x00A5 held until ACK; return to IDLE; WbREQ never asserts.
REQ-022 Command Tag = 7, ResponseRequested = 1; device responds after 5 cycles with RegFlag = 1, Data = 0x1234 -> WbREQ with WbDestReg = 7, WbData = 0x1234, WbTimeout = 0; manager withholds WbACK 3 cycles -> payload stable throughout.
REQ-023 TIMEOUTCYCLES = 4, ResponseRequested = 1, no device response -> WbREQ asserts 4 cycles after WAIT_RESP entry with WbData = 0xFFFF, WbTimeout = 1.
REQ-024 TIMEOUTCYCLES = 4, IOIn_REQ asserted exactly on terminal count with Data = 0x0042 -> writeback carries 0x0042 with WbTimeout = 0.
REQ-025 clk_en low for 3 cycles during WAIT_RESP -> counter and outputs frozen; timeout delayed by exactly 3 cycles.
REQ-026 sync_rst asserted in ISSUE and in WRITEBACK -> next cycle IDLE, CmdACK = 1, IOOut_REQ = 0, WbREQ = 0; a subsequent command completes normally.
